// File: rtl/mcpu_ctrl.sv
// Multi-cycle MIPS control unit: sequences fetch/decode/execute/memory/writeback
// over a shared-memory datapath, with a memory wait timeout and an illegal-instruction trap.
module mcpu_ctrl #(
  parameter int WAIT_LIMIT = 16,
  parameter int CNT_W      = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] OPcode,
  input  logic [5:0] Fun,
  input  logic       MIO_ready,
  input  logic       zero,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       CPU_MIO,
  output logic [1:0] RegDst,
  output logic [1:0] DatatoReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [2:0] ALU_Control,
  output logic [3:0] state,
  output logic       bus_err,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_IF    = 4'd0,
    S_ID    = 4'd1,
    S_MADDR = 4'd2,
    S_MRD   = 4'd3,
    S_WBL   = 4'd4,
    S_MWR   = 4'd5,
    S_EXR   = 4'd6,
    S_WBR   = 4'd7,
    S_BR    = 4'd8,
    S_J     = 4'd9,
    S_JAL   = 4'd10,
    S_EXI   = 4'd11,
    S_WBI   = 4'd12,
    S_LUI   = 4'd13,
    S_JR    = 4'd14,
    S_ILL   = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] F_SRL = 6'b000010;
  localparam logic [5:0] F_JR  = 6'b001000;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_XOR = 6'b100110;
  localparam logic [5:0] F_NOR = 6'b100111;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam bit             TIMEOUT_EN = (WAIT_LIMIT != 0);
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(WAIT_LIMIT - 1);

  function automatic logic r_fun_ok(input logic [5:0] f);
    case (f)
      F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SRL: return 1'b1;
      default:                                              return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] r_alu_op(input logic [5:0] f);
    case (f)
      F_SUB:   return ALU_SUB;
      F_AND:   return ALU_AND;
      F_OR:    return ALU_OR;
      F_XOR:   return ALU_XOR;
      F_NOR:   return ALU_NOR;
      F_SLT:   return ALU_SLT;
      F_SRL:   return ALU_SRL;
      default: return ALU_ADD;
    endcase
  endfunction

  function automatic logic [2:0] i_alu_op(input logic [5:0] op);
    case (op)
      OP_SLTI: return ALU_SLT;
      OP_ANDI: return ALU_AND;
      OP_ORI:  return ALU_OR;
      OP_XORI: return ALU_XOR;
      default: return ALU_ADD;
    endcase
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt;
  logic             bus_err_q;
  logic             mem_state;
  logic             timeout;

  assign mem_state = (state_q == S_IF) || (state_q == S_MRD) || (state_q == S_MWR);
  // A ready in the limit cycle still completes the access, so timeout needs ready low.
  assign timeout   = TIMEOUT_EN && mem_state && !MIO_ready && (wait_cnt == LAST_WAIT);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IF;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst)
      wait_cnt <= '0;
    else if (mem_state && !MIO_ready && !timeout && (wait_cnt != '1))
      wait_cnt <= wait_cnt + 1'b1;
    else
      wait_cnt <= '0;
  end

  always_ff @(posedge clk) begin
    if (rst)          bus_err_q <= 1'b0;
    else if (timeout) bus_err_q <= 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    PCWrite     = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 2'b00;
    DatatoReg   = 2'b00;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    PCSource    = 2'b00;
    ALU_Control = ALU_ADD;
    illegal     = 1'b0;

    case (state_q)
      S_IF: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = MIO_ready;
        PCWrite = MIO_ready;
        if (MIO_ready) state_d = S_ID;
      end
      S_ID: begin
        ALUSrcB = 2'b11;
        case (OPcode)
          OP_RTYPE: begin
            if (Fun == F_JR)       state_d = S_JR;
            else if (r_fun_ok(Fun)) state_d = S_EXR;
            else                    state_d = S_ILL;
          end
          OP_LW, OP_SW:                            state_d = S_MADDR;
          OP_BEQ, OP_BNE:                          state_d = S_BR;
          OP_J:                                    state_d = S_J;
          OP_JAL:                                  state_d = S_JAL;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: state_d = S_EXI;
          OP_LUI:                                  state_d = S_LUI;
          default:                                 state_d = S_ILL;
        endcase
      end
      S_MADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        if (OPcode == OP_SW)      state_d = S_MWR;
        else if (OPcode == OP_LW) state_d = S_MRD;
        else                      state_d = S_IF;
      end
      S_MRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (MIO_ready)    state_d = S_WBL;
        else if (timeout) state_d = S_IF;
      end
      S_WBL: begin
        RegWrite  = 1'b1;
        DatatoReg = 2'b01;
        state_d   = S_IF;
      end
      S_MWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (MIO_ready || timeout) state_d = S_IF;
      end
      S_EXR: begin
        ALUSrcA     = 1'b1;
        ALU_Control = r_alu_op(Fun);
        state_d     = S_WBR;
      end
      S_WBR: begin
        RegWrite    = 1'b1;
        RegDst      = 2'b01;
        ALU_Control = r_alu_op(Fun);
        state_d     = S_IF;
      end
      S_BR: begin
        ALUSrcA     = 1'b1;
        ALU_Control = ALU_SUB;
        PCSource    = 2'b01;
        PCWrite     = (OPcode == OP_BEQ) ? zero : ~zero;
        state_d     = S_IF;
      end
      S_J: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        state_d  = S_IF;
      end
      S_JAL: begin
        PCWrite   = 1'b1;
        PCSource  = 2'b10;
        RegWrite  = 1'b1;
        RegDst    = 2'b10;
        DatatoReg = 2'b11;
        state_d   = S_IF;
      end
      S_EXI: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = 2'b10;
        ALU_Control = i_alu_op(OPcode);
        state_d     = S_WBI;
      end
      S_WBI: begin
        RegWrite    = 1'b1;
        ALU_Control = i_alu_op(OPcode);
        state_d     = S_IF;
      end
      S_LUI: begin
        RegWrite  = 1'b1;
        DatatoReg = 2'b10;
        state_d   = S_IF;
      end
      S_JR: begin
        PCWrite  = 1'b1;
        PCSource = 2'b11;
        state_d  = S_IF;
      end
      S_ILL: begin
        illegal = 1'b1;
        state_d = S_IF;
      end
      default: state_d = S_IF;
    endcase

    // Reset silences the datapath immediately rather than waiting for the edge.
    if (rst) begin
      PCWrite     = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      RegWrite    = 1'b0;
      RegDst      = 2'b00;
      DatatoReg   = 2'b00;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      PCSource    = 2'b00;
      ALU_Control = ALU_ADD;
      illegal     = 1'b0;
    end
  end

  assign CPU_MIO = MemRead | MemWrite;
  assign state   = state_q;
  assign bus_err = bus_err_q;

endmodule

// File: tb/tb_mcpu_ctrl.sv
// Directed self-checking bench for mcpu_ctrl, built with a short wait limit (4)
// so the timeout and ready-at-limit boundary are reachable in a few cycles.
module tb_mcpu_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] OPcode;
  logic [5:0] Fun;
  logic       MIO_ready;
  logic       zero;
  logic       PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite, CPU_MIO;
  logic [1:0] RegDst, DatatoReg, ALUSrcB, PCSource;
  logic       ALUSrcA;
  logic [2:0] ALU_Control;
  logic [3:0] state;
  logic       bus_err, illegal;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mcpu_ctrl #(.WAIT_LIMIT(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .OPcode(OPcode), .Fun(Fun), .MIO_ready(MIO_ready), .zero(zero),
    .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .CPU_MIO(CPU_MIO), .RegDst(RegDst),
    .DatatoReg(DatatoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .ALU_Control(ALU_Control), .state(state), .bus_err(bus_err), .illegal(illegal)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; OPcode = 6'b0; Fun = 6'b0; MIO_ready = 1'b1; zero = 1'b0;
    tick(); tick(); #1;
    total++; if (state !== 4'd0) $display("[TB] FAIL reset_state: got %0d expected 0", state); else passed++;
    total++; if (bus_err !== 1'b0) $display("[TB] FAIL reset_bus_err: got %b expected 0", bus_err); else passed++;
    total++; if ({PCWrite, IRWrite, MemRead, MemWrite, RegWrite, CPU_MIO, illegal} !== 7'b0)
      $display("[TB] FAIL reset_strobes: got %b expected 0000000",
               {PCWrite, IRWrite, MemRead, MemWrite, RegWrite, CPU_MIO, illegal}); else passed++;
    total++; if ({ALUSrcB, ALU_Control} !== 5'b00_010)
      $display("[TB] FAIL reset_selects: got %b expected 00010", {ALUSrcB, ALU_Control}); else passed++;
    rst = 1'b0; #1;
    total++; if ({MemRead, IRWrite, PCWrite, ALUSrcB} !== 5'b111_01)
      $display("[TB] FAIL if_ready: got %b expected 11101", {MemRead, IRWrite, PCWrite, ALUSrcB}); else passed++;
    MIO_ready = 1'b0; #1;
    total++; if ({IRWrite, PCWrite} !== 2'b00)
      $display("[TB] FAIL if_not_ready: got %b expected 00", {IRWrite, PCWrite}); else passed++;
  endtask

  task automatic test_rtype_add();
    logic [3:0] est [5];
    logic       erw [5];
    est = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
    erw = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    OPcode = 6'b000000; Fun = 6'b100000; MIO_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++; if (state !== est[i]) $display("[TB] FAIL add_state[%0d]: got %0d expected %0d", i, state, est[i]); else passed++;
      total++; if (RegWrite !== erw[i]) $display("[TB] FAIL add_regwrite[%0d]: got %b expected %b", i, RegWrite, erw[i]); else passed++;
      if (i == 3) begin
        total++; if ({RegDst, DatatoReg, ALU_Control} !== 7'b01_00_010)
          $display("[TB] FAIL add_wb: got %b expected 0100010", {RegDst, DatatoReg, ALU_Control}); else passed++;
      end
      if (i < 4) tick();
    end
  endtask

  task automatic test_rtype_ops();
    logic [5:0] funs [7];
    logic [2:0] ops  [7];
    funs = '{6'b100010, 6'b101010, 6'b000010, 6'b100111, 6'b100100, 6'b100101, 6'b100110};
    ops  = '{3'b110,    3'b111,    3'b101,    3'b100,    3'b000,    3'b001,    3'b011};
    OPcode = 6'b000000; MIO_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      Fun = funs[i];
      tick(); tick(); #1;
      total++; if ({state, ALUSrcA, ALUSrcB, ALU_Control} !== {4'd6, 1'b1, 2'b00, ops[i]})
        $display("[TB] FAIL exr_fun%b: got %b expected %b", funs[i],
                 {state, ALUSrcA, ALUSrcB, ALU_Control}, {4'd6, 1'b1, 2'b00, ops[i]}); else passed++;
      tick(); #1;
      total++; if ({state, RegWrite, ALU_Control} !== {4'd7, 1'b1, ops[i]})
        $display("[TB] FAIL wbr_fun%b: got %b expected %b", funs[i],
                 {state, RegWrite, ALU_Control}, {4'd7, 1'b1, ops[i]}); else passed++;
      tick();
    end
  endtask

  task automatic test_lw_wait();
    logic       rdy [8];
    logic [3:0] est [8];
    logic [1:0] emi [8];
    int         rw_cnt;
    rdy = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    est = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4};
    emi = '{2'b10, 2'b00, 2'b00, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00};
    rw_cnt = 0;
    OPcode = 6'b100011; Fun = 6'b0;
    for (int i = 0; i < 8; i++) begin
      MIO_ready = rdy[i]; #1;
      total++; if (state !== est[i]) $display("[TB] FAIL lw_state[%0d]: got %0d expected %0d", i, state, est[i]); else passed++;
      total++; if ({MemRead, IorD} !== emi[i]) $display("[TB] FAIL lw_memrd[%0d]: got %b expected %b", i, {MemRead, IorD}, emi[i]); else passed++;
      if (RegWrite === 1'b1 && DatatoReg === 2'b01) rw_cnt++;
      tick();
    end
    #1;
    total++; if (state !== 4'd0) $display("[TB] FAIL lw_return: got %0d expected 0", state); else passed++;
    total++; if (rw_cnt !== 1) $display("[TB] FAIL lw_regwrites: got %0d expected 1", rw_cnt); else passed++;
    total++; if (bus_err !== 1'b0) $display("[TB] FAIL lw_ready_at_limit: got bus_err %b expected 0", bus_err); else passed++;
  endtask

  task automatic test_branch();
    logic [5:0] ops [4];
    logic       zs  [4];
    logic       epc [4];
    ops = '{6'b000100, 6'b000100, 6'b000101, 6'b000101};
    zs  = '{1'b1, 1'b0, 1'b1, 1'b0};
    epc = '{1'b1, 1'b0, 1'b0, 1'b1};
    MIO_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      OPcode = ops[i]; zero = zs[i];
      tick(); tick(); #1;
      total++; if ({state, PCWrite, PCSource, ALU_Control} !== {4'd8, epc[i], 2'b01, 3'b110})
        $display("[TB] FAIL branch[%0d]: got %b expected %b", i,
                 {state, PCWrite, PCSource, ALU_Control}, {4'd8, epc[i], 2'b01, 3'b110}); else passed++;
      tick(); #1;
      total++; if (state !== 4'd0) $display("[TB] FAIL branch_return[%0d]: got %0d expected 0", i, state); else passed++;
    end
    zero = 1'b0;
  endtask

  task automatic test_itype();
    logic [5:0] ops [5];
    logic [2:0] alu [5];
    ops = '{6'b001000, 6'b001010, 6'b001100, 6'b001101, 6'b001110};
    alu = '{3'b010,    3'b111,    3'b000,    3'b001,    3'b011};
    MIO_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      OPcode = ops[i];
      tick(); tick(); #1;
      total++; if ({state, ALUSrcA, ALUSrcB, ALU_Control} !== {4'd11, 1'b1, 2'b10, alu[i]})
        $display("[TB] FAIL exi_op%b: got %b expected %b", ops[i],
                 {state, ALUSrcA, ALUSrcB, ALU_Control}, {4'd11, 1'b1, 2'b10, alu[i]}); else passed++;
      tick(); #1;
      total++; if ({state, RegWrite, RegDst, DatatoReg, ALU_Control} !== {4'd12, 1'b1, 2'b00, 2'b00, alu[i]})
        $display("[TB] FAIL wbi_op%b: got %b expected %b", ops[i],
                 {state, RegWrite, RegDst, DatatoReg, ALU_Control}, {4'd12, 1'b1, 2'b00, 2'b00, alu[i]}); else passed++;
      tick();
    end
  endtask

  // Expected bits: {PCWrite, RegWrite, RegDst, DatatoReg, PCSource, illegal}
  task automatic test_jumps_illegal();
    logic [5:0] ops  [6];
    logic [5:0] funs [6];
    logic [3:0] est  [6];
    logic [8:0] eout [6];
    ops  = '{6'b000010, 6'b000011, 6'b001111, 6'b000000, 6'b111111, 6'b000000};
    funs = '{6'b000000, 6'b000000, 6'b000000, 6'b001000, 6'b000000, 6'b111111};
    est  = '{4'd9, 4'd10, 4'd13, 4'd14, 4'd15, 4'd15};
    eout = '{9'b1_0_00_00_10_0, 9'b1_1_10_11_10_0, 9'b0_1_00_10_00_0,
             9'b1_0_00_00_11_0, 9'b0_0_00_00_00_1, 9'b0_0_00_00_00_1};
    MIO_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      OPcode = ops[i]; Fun = funs[i];
      tick(); #1;
      total++; if ({state, illegal} !== {4'd1, 1'b0})
        $display("[TB] FAIL id_phase[%0d]: got %b expected 00010", i, {state, illegal}); else passed++;
      tick(); #1;
      total++; if (state !== est[i]) $display("[TB] FAIL exec_state[%0d]: got %0d expected %0d", i, state, est[i]); else passed++;
      total++; if ({PCWrite, RegWrite, RegDst, DatatoReg, PCSource, illegal} !== eout[i])
        $display("[TB] FAIL exec_out[%0d]: got %b expected %b", i,
                 {PCWrite, RegWrite, RegDst, DatatoReg, PCSource, illegal}, eout[i]); else passed++;
      total++; if ({MemWrite, IRWrite} !== 2'b00)
        $display("[TB] FAIL exec_nowrite[%0d]: got %b expected 00", i, {MemWrite, IRWrite}); else passed++;
      tick(); #1;
      total++; if ({state, illegal} !== {4'd0, 1'b0})
        $display("[TB] FAIL exec_return[%0d]: got %b expected 00000", i, {state, illegal}); else passed++;
    end
    Fun = 6'b0;
  endtask

  task automatic test_sw_timeout();
    logic       rdy [7];
    logic [3:0] est [7];
    logic [1:0] emw [7];
    rdy = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    est = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5, 4'd5};
    emw = '{2'b01, 2'b00, 2'b00, 2'b11, 2'b11, 2'b11, 2'b11};
    OPcode = 6'b101011;
    for (int i = 0; i < 7; i++) begin
      MIO_ready = rdy[i]; #1;
      total++; if ({state, bus_err} !== {est[i], 1'b0})
        $display("[TB] FAIL sw_state[%0d]: got %b expected %b", i, {state, bus_err}, {est[i], 1'b0}); else passed++;
      total++; if ({MemWrite, CPU_MIO} !== emw[i])
        $display("[TB] FAIL sw_memwr[%0d]: got %b expected %b", i, {MemWrite, CPU_MIO}, emw[i]); else passed++;
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      #1;
      total++; if ({state, bus_err, MemWrite, IRWrite, PCWrite} !== {4'd0, 1'b1, 3'b000})
        $display("[TB] FAIL sw_after_timeout[%0d]: got %b expected 00001000", i,
                 {state, bus_err, MemWrite, IRWrite, PCWrite}); else passed++;
      tick();
    end
  endtask

  task automatic test_reset_mid_access();
    OPcode = 6'b100011; MIO_ready = 1'b1;
    tick();
    MIO_ready = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1; #1;
    total++; if (state !== 4'd3) $display("[TB] FAIL rst_mid_prestate: got %0d expected 3", state); else passed++;
    total++; if ({MemRead, IorD, CPU_MIO, RegWrite, MemWrite, PCWrite, IRWrite, ALU_Control} !== 10'b0000000_010)
      $display("[TB] FAIL rst_mid_outputs: got %b expected 0000000010",
               {MemRead, IorD, CPU_MIO, RegWrite, MemWrite, PCWrite, IRWrite, ALU_Control}); else passed++;
    tick(); #1;
    total++; if ({state, bus_err} !== 5'b0000_0)
      $display("[TB] FAIL rst_mid_after: got %b expected 00000", {state, bus_err}); else passed++;
    rst = 1'b0; #1;
    total++; if ({MemRead, IorD} !== 2'b10)
      $display("[TB] FAIL rst_mid_refetch: got %b expected 10", {MemRead, IorD}); else passed++;
  endtask

  initial begin
    test_reset();
    test_rtype_add();
    test_rtype_ops();
    test_lw_wait();
    test_branch();
    test_itype();
    test_jumps_illegal();
    test_sw_timeout();
    test_reset_mid_access();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation did not complete");
  end

endmodule
